// File: rtl/position_averager_pkg.sv
// rtl/position_averager_pkg.sv - shared types and constants for the trilateration back end
package position_averager_pkg;

  localparam int CLK_HZ             = 31250000;
  localparam int X_W                = 32;
  localparam int Y_W                = 16;
  localparam int X_MIN_DEF          = -4000;
  localparam int X_MAX_DEF          = 4000;
  localparam int TIMEOUT_CYCLES_DEF = CLK_HZ;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    ACC  = 3'd3,
    AVG  = 3'd4,
    HOLD = 3'd5
  } avg_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/position_averager_accum.sv
// rtl/position_averager_accum.sv - range gate, signed accumulators, sample count and shift-average
module pos_accumulator
  import position_averager_pkg::*;
#(
  parameter int LOG2N = 2,
  parameter int X_MIN = X_MIN_DEF,
  parameter int X_MAX = X_MAX_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  add_i,
  input  logic                  clr_i,
  input  logic                  load_avg_i,
  input  logic signed [X_W-1:0] x_i,
  input  logic signed [Y_W-1:0] y_i,
  output logic                  accept_o,
  output logic                  full_o,
  output logic signed [X_W-1:0] avg_x_o,
  output logic signed [Y_W-1:0] avg_y_o
);

  localparam int AXW = X_W + LOG2N;
  localparam int AYW = Y_W + LOG2N;
  localparam logic [LOG2N:0] N_LAST = {1'b0, {LOG2N{1'b1}}};
  localparam logic [LOG2N:0] N_ONE  = {{LOG2N{1'b0}}, 1'b1};

  logic signed [AXW-1:0] acc_x_q, acc_x_d, sh_x;
  logic signed [AYW-1:0] acc_y_q, acc_y_d, sh_y;
  logic [LOG2N:0]        n_q, n_d;
  logic signed [X_W-1:0] avg_x_q, avg_x_d;
  logic signed [Y_W-1:0] avg_y_q, avg_y_d;

  assign accept_o = (x_i >= X_MIN) && (x_i <= X_MAX);
  // full_o flags that the sample being added right now completes the set
  assign full_o   = accept_o && (n_q == N_LAST);

  assign sh_x = acc_x_q >>> LOG2N;
  assign sh_y = acc_y_q >>> LOG2N;

  always_comb begin
    acc_x_d = acc_x_q;
    acc_y_d = acc_y_q;
    n_d     = n_q;
    avg_x_d = avg_x_q;
    avg_y_d = avg_y_q;
    if (clr_i) begin
      acc_x_d = '0;
      acc_y_d = '0;
      n_d     = '0;
    end else if (load_avg_i) begin
      avg_x_d = sh_x[X_W-1:0];
      avg_y_d = sh_y[Y_W-1:0];
      acc_x_d = '0;
      acc_y_d = '0;
      n_d     = '0;
    end else if (add_i && accept_o) begin
      acc_x_d = acc_x_q + {{LOG2N{x_i[X_W-1]}}, x_i};
      acc_y_d = acc_y_q + {{LOG2N{y_i[Y_W-1]}}, y_i};
      n_d     = n_q + N_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_x_q <= '0;
      acc_y_q <= '0;
      n_q     <= '0;
      avg_x_q <= '0;
      avg_y_q <= '0;
    end else begin
      acc_x_q <= acc_x_d;
      acc_y_q <= acc_y_d;
      n_q     <= n_d;
      avg_x_q <= avg_x_d;
      avg_y_q <= avg_y_d;
    end
  end

  assign avg_x_o = avg_x_q;
  assign avg_y_o = avg_y_q;

endmodule

// File: rtl/position_averager.sv
// rtl/position_averager.sv - requests measurements, gates and averages positions, counts faults
module position_averager
  import position_averager_pkg::*;
#(
  parameter int LOG2N          = 2,
  parameter int X_MIN          = X_MIN_DEF,
  parameter int X_MAX          = X_MAX_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  complete,
  input  logic signed [X_W-1:0] X,
  input  logic signed [Y_W-1:0] Y,
  output logic                  meas_start,
  output logic signed [X_W-1:0] avg_x,
  output logic signed [Y_W-1:0] avg_y,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            reject_cnt,
  output logic [7:0]            timeout_cnt
);

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  avg_state_e            state_q, state_d;
  logic [31:0]           timer_q, timer_d;
  logic                  complete_d_q;
  logic                  rise;
  logic signed [X_W-1:0] x_samp_q, x_samp_d;
  logic signed [Y_W-1:0] y_samp_q, y_samp_d;
  logic                  out_valid_q, out_valid_d;
  logic [7:0]            reject_cnt_q, reject_cnt_d;
  logic [7:0]            timeout_cnt_q, timeout_cnt_d;
  logic                  acc_add, acc_load, acc_accept, acc_full;
  logic                  meas_start_c;

  assign rise = complete & ~complete_d_q;

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    x_samp_d      = x_samp_q;
    y_samp_d      = y_samp_q;
    out_valid_d   = out_valid_q;
    reject_cnt_d  = reject_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    acc_add       = 1'b0;
    acc_load      = 1'b0;
    meas_start_c  = 1'b0;
    unique case (state_q)
      IDLE: if (enable) state_d = REQ;
      REQ: begin
        meas_start_c = 1'b1;
        timer_d      = '0;
        state_d      = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + 32'd1;
        // a completion that lands on the last timer cycle still wins
        if (rise) begin
          x_samp_d = X;
          y_samp_d = Y;
          state_d  = ACC;
        end else if (timer_q == TO_LAST) begin
          timeout_cnt_d = sat_inc8(timeout_cnt_q);
          state_d       = REQ;
        end
      end
      ACC: begin
        acc_add = 1'b1;
        if (!acc_accept) reject_cnt_d = sat_inc8(reject_cnt_q);
        if (acc_full)    state_d = AVG;
        else if (enable) state_d = REQ;
        else             state_d = IDLE;
      end
      AVG: begin
        acc_load    = 1'b1;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d       = IDLE;
      out_valid_d   = 1'b0;
      timer_d       = '0;
      reject_cnt_d  = '0;
      timeout_cnt_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      complete_d_q  <= 1'b0;
      x_samp_q      <= '0;
      y_samp_q      <= '0;
      out_valid_q   <= 1'b0;
      reject_cnt_q  <= '0;
      timeout_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      complete_d_q  <= complete;
      x_samp_q      <= x_samp_d;
      y_samp_q      <= y_samp_d;
      out_valid_q   <= out_valid_d;
      reject_cnt_q  <= reject_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
    end
  end

  pos_accumulator #(
    .LOG2N (LOG2N),
    .X_MIN (X_MIN),
    .X_MAX (X_MAX)
  ) u_acc (
    .clk_i      (CLK),
    .rst_i      (RST),
    .add_i      (acc_add),
    .clr_i      (clear),
    .load_avg_i (acc_load),
    .x_i        (x_samp_q),
    .y_i        (y_samp_q),
    .accept_o   (acc_accept),
    .full_o     (acc_full),
    .avg_x_o    (avg_x),
    .avg_y_o    (avg_y)
  );

  assign meas_start  = meas_start_c;
  assign out_valid   = out_valid_q;
  assign reject_cnt  = reject_cnt_q;
  assign timeout_cnt = timeout_cnt_q;

endmodule

// File: tb/tb_position_averager.sv
// tb/tb_position_averager.sv - directed bench with a sample-queue averaging model
module tb_position_averager;

  localparam int N     = 4;
  localparam int XMIN  = -4000;
  localparam int XMAX  = 4000;

  logic               CLK = 1'b0;
  logic               RST = 1'b1;
  logic               enable = 1'b0;
  logic               clear = 1'b0;
  logic               complete = 1'b0;
  logic signed [31:0] X = '0;
  logic signed [15:0] Y = '0;
  logic               meas_start;
  logic signed [31:0] avg_x;
  logic signed [15:0] avg_y;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [7:0]         reject_cnt;
  logic [7:0]         timeout_cnt;

  position_averager #(
    .LOG2N(2), .X_MIN(XMIN), .X_MAX(XMAX), .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK(CLK), .RST(RST), .enable(enable), .clear(clear), .complete(complete),
    .X(X), .Y(Y), .meas_start(meas_start), .avg_x(avg_x), .avg_y(avg_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .reject_cnt(reject_cnt), .timeout_cnt(timeout_cnt)
  );

  always #5 CLK = ~CLK;

  int     cyc = 0;
  int     n_pass = 0;
  int     n_chk = 0;
  int     ms_count = 0;
  // model state
  int     qx[$];
  int     qy[$];
  longint exp_avg_x = 0;
  longint exp_avg_y = 0;
  int     model_rej = 0;
  bit     pend_valid = 0;
  int     valid_due = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic longint floor_div(input longint s, input longint d);
    longint q = s / d;
    if ((s % d != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  // per-cycle comparison against the model
  always @(negedge CLK) begin
    if (meas_start) ms_count++;
    if (!RST) begin
      if (pend_valid) begin
        if (cyc < valid_due) chk("valid_early", out_valid, 0);
        else begin
          chk("valid_latency", out_valid, 1);
          pend_valid = 0;
        end
      end
      if (out_valid) begin
        chk("avg_x", $signed(avg_x), exp_avg_x);
        chk("avg_y", $signed(avg_y), exp_avg_y);
        chk("no_start_in_hold", meas_start, 0);
      end
    end
  end

  task automatic wait_ms(output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (meas_start) begin ok = 1; break; end
    end
    chk("meas_start_seen", ok, 1);
  endtask

  task automatic wait_valid();
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (out_valid) begin ok = 1; break; end
    end
    chk("out_valid_seen", ok, 1);
  endtask

  task automatic do_meas(input int x, input int y);
    bit ok;
    longint sx, sy;
    wait_ms(ok);
    if (!ok) return;
    @(negedge CLK);
    @(negedge CLK);
    X = x; Y = 16'(y); complete = 1'b1;
    if (x >= XMIN && x <= XMAX) begin
      qx.push_back(x); qy.push_back(y);
      if (qx.size() == N) begin
        sx = 0; sy = 0;
        foreach (qx[i]) begin sx += qx[i]; sy += qy[i]; end
        exp_avg_x = floor_div(sx, N);
        exp_avg_y = floor_div(sy, N);
        qx.delete(); qy.delete();
        pend_valid = 1;
        valid_due = cyc + 3;
      end
    end else if (model_rej < 255) model_rej++;
    @(negedge CLK);
    complete = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge CLK);
    chk("valid_drop", out_valid, 0);
    out_ready = 1'b0;
  endtask

  int t1x[4] = '{100, 104, 108, 112};
  int t1y[4] = '{50, 50, 52, 52};
  int t2x[4] = '{-3, -4, -4, -4};
  int t2y[4] = '{-1, 0, 0, 0};
  int t3x[5] = '{100, 5000, 100, 100, 100};
  int t5x[4] = '{8, 8, 12, 12};
  int t5y[4] = '{-8, -8, -4, -4};

  initial begin
    int snap, last_ms;
    bit ok;
    repeat (3) @(negedge CLK);
    chk("rst_meas_start", meas_start, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_avg_x", avg_x, 0);
    chk("rst_avg_y", avg_y, 0);
    chk("rst_reject", reject_cnt, 0);
    chk("rst_timeout", timeout_cnt, 0);
    RST = 1'b0;
    @(negedge CLK);

    // average of four, then a stalled consumer with complete toggling
    snap = ms_count; enable = 1'b1;
    for (int i = 0; i < 4; i++) do_meas(t1x[i], t1y[i]);
    enable = 1'b0;
    wait_valid();
    chk("t1_avg_x", $signed(avg_x), 106);
    chk("t1_avg_y", $signed(avg_y), 51);
    chk("t1_starts", ms_count - snap, 4);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      complete = ~complete; X = $urandom_range(0, 3000);
      chk("hold_valid", out_valid, 1);
    end
    complete = 1'b0;
    chk("hold_avg_x", $signed(avg_x), 106);
    chk("hold_avg_y", $signed(avg_y), 51);
    handshake();
    snap = ms_count;
    repeat (4) @(negedge CLK);
    chk("idle_no_start", ms_count - snap, 0);

    // negative samples floor toward minus infinity
    snap = ms_count; enable = 1'b1;
    for (int i = 0; i < 4; i++) do_meas(t2x[i], t2y[i]);
    enable = 1'b0;
    wait_valid();
    chk("t2_avg_x", $signed(avg_x), -4);
    chk("t2_avg_y", $signed(avg_y), -1);
    handshake();

    // one out-of-range sample is rejected and re-requested
    snap = ms_count; enable = 1'b1;
    for (int i = 0; i < 5; i++) do_meas(t3x[i], 7);
    enable = 1'b0;
    wait_valid();
    chk("t3_avg_x", $signed(avg_x), 100);
    chk("t3_reject", reject_cnt, 1);
    chk("t3_reject_model", reject_cnt, model_rej);
    chk("t3_starts", ms_count - snap, 5);
    chk("t3_timeout", timeout_cnt, 0);
    handshake();

    // timeouts: one request per 17 cycles, counter saturates
    enable = 1'b1;
    last_ms = 0;
    for (int k = 1; k <= 260; k++) begin
      wait_ms(ok);
      if (!ok) break;
      if (k > 1) chk("timeout_period", cyc - last_ms, 17);
      chk("timeout_cnt", timeout_cnt, (k - 1 > 255) ? 255 : k - 1);
      last_ms = cyc;
    end
    clear = 1'b1; enable = 1'b0;
    @(negedge CLK);
    clear = 1'b0;
    model_rej = 0;
    chk("clr_timeout", timeout_cnt, 0);
    chk("clr_reject", reject_cnt, 0);
    chk("clr_valid", out_valid, 0);
    chk("clr_keep_avg_x", $signed(avg_x), 100);
    chk("clr_keep_avg_y", $signed(avg_y), 7);
    snap = ms_count;
    repeat (20) @(negedge CLK);
    chk("clr_idle", ms_count - snap, 0);

    // reset mid-WAIT, late complete must be ignored
    enable = 1'b1;
    wait_ms(ok);
    @(negedge CLK);
    RST = 1'b1; enable = 1'b0;
    @(negedge CLK);
    RST = 1'b0; complete = 1'b1; X = 3000; Y = 16'sd3000;
    qx.delete(); qy.delete(); pend_valid = 0; model_rej = 0;
    exp_avg_x = 0; exp_avg_y = 0;
    snap = ms_count;
    repeat (10) @(negedge CLK);
    chk("rstw_starts", ms_count - snap, 0);
    chk("rstw_valid", out_valid, 0);
    chk("rstw_avg_x", avg_x, 0);
    chk("rstw_avg_y", avg_y, 0);
    chk("rstw_timeout", timeout_cnt, 0);
    complete = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) do_meas(t5x[i], t5y[i]);
    enable = 1'b0;
    wait_valid();
    chk("t5_avg_x", $signed(avg_x), 10);
    chk("t5_avg_y", $signed(avg_y), -6);
    handshake();

    repeat (3) @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/position_averager.md
Name: position_averager

Overview:
- Downstream consumer of the trilateration math stage (X signed 32-bit, Y signed 16-bit, `complete`).
- Requests one measurement at a time by pulsing the math stage's start input, then captures each finished (X,Y).
- Rejects out-of-range X, accumulates 2^LOG2N accepted samples, and presents the averaged position on a valid/ready output.
- Counts timeouts and rejections for debug and display.

Parameters:
- LOG2N, 2, log2 of the number of accepted samples per average (1..6).
- X_MIN, -4000, lowest accepted X in scaled units, inclusive.
- X_MAX, 4000, highest accepted X in scaled units, inclusive.
- TIMEOUT_CYCLES, 31250000, number of WAIT cycles before a measurement is abandoned (1 s at 31.25 MHz).

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset, synchronous, active-high.
- enable  in  1  level; while high, the block keeps requesting measurements.
- clear  in  1  synchronous soft clear; priority directly below RST.
- complete  in  1  done level from the math stage; only its rising edge is used.
- X  in  32  signed X from the math stage.
- Y  in  16  signed Y from the math stage.
- meas_start  out  1  one-cycle pulse; drives the math stage start input.
- avg_x  out  32  signed averaged X.
- avg_y  out  16  signed averaged Y.
- out_valid  out  1  averaged result available.
- out_ready  in  1  consumer accepts the result.
- reject_cnt  out  8  saturating count of out-of-range samples.
- timeout_cnt  out  8  saturating count of measurement timeouts.

Behaviour:
- Reset (RST high at an edge): state IDLE.
  - All outputs 0.
  - Accumulators, sample count n, wait timer, and complete_d all 0.
- Edge detect: complete_d <= complete every cycle. rise = complete & ~complete_d.
  - A complete level that is already high when WAIT is entered does not count as a rise.
- IDLE: if enable, go to REQ; otherwise stay.
- REQ: meas_start = 1 for exactly this cycle; timer cleared; go to WAIT.
- WAIT: timer increments each cycle.
  - On rise, X and Y are registered into the sample registers at the same edge; go to ACC.
  - Else, if timer == TIMEOUT_CYCLES-1: timeout_cnt++ (saturating at 255); go to REQ.
  - Rise and timeout in the same cycle: rise wins, no timeout is counted.
  - enable falling during WAIT does not abort the measurement in progress.
- ACC: a sample is accepted if X_MIN <= X <= X_MAX.
  - Accepted: acc_x += sign-extended X, acc_y += sign-extended Y, n++.
  - Rejected: reject_cnt++ (saturating at 255); accumulators unchanged.
  - Next state: if n reaches 2^LOG2N, go to AVG; else if enable, go to REQ; else go to IDLE (partial sums held).
- Accumulator widths: acc_x is 32+LOG2N bits, acc_y is 16+LOG2N bits, both signed; no overflow is possible.
- AVG: avg_x <= acc_x >>> LOG2N and avg_y <= acc_y >>> LOG2N.
  - Arithmetic shift, so the result floors toward negative infinity.
  - out_valid <= 1; accumulators and n cleared; go to HOLD.
- Latency: if the final rise is sampled at edge e0, out_valid and the averages are registered at edge e0+2.
- HOLD: out_valid stays high; avg_x and avg_y are stable.
  - No meas_start is issued and complete edges are ignored.
  - On out_valid & out_ready at an edge: out_valid <= 0; go to IDLE.
- clear: go to IDLE.
  - out_valid, the accumulators, n, the timer, reject_cnt and timeout_cnt all go to 0.
  - avg_x and avg_y keep their last values.
- RST or clear mid-WAIT: a late complete from the math stage is edge-detected only in WAIT, so it is discarded.

Decomposition:
- Shared package (alongside the math-stage definitions) holds:
  - the state enum {IDLE, REQ, WAIT, ACC, AVG, HOLD};
  - the default X_MIN, X_MAX and TIMEOUT_CYCLES constants;
  - the clock-speed constant 31250000.
- One sub-module: pos_accumulator, containing the range gate, the two signed accumulators, the sample counter and the shift-average, with controls add, clr and load_avg.
- The FSM, timer and edge detect stay in the top module.

Test Plan:
- LOG2N=2, samples X=100,104,108,112 and Y=50,50,52,52 -> four meas_start pulses; avg_x=106, avg_y=51; out_valid at e0+2 after the 4th rise.
- Samples X=-3,-4,-4,-4 and Y=-1,0,0,0 -> avg_x=-4 (floor of -3.75), avg_y=-1.
- Samples X=100,5000,100,100,100 -> reject_cnt=1, five meas_start pulses, avg_x=100.
- TIMEOUT_CYCLES=16, complete held low -> meas_start pulses every 17 cycles; timeout_cnt increments each time and saturates at 255.
- out_ready held low for 10 cycles in HOLD, complete toggled during that time -> avg values stable, no meas_start; out_valid drops one edge after out_ready rises; state IDLE.
- RST asserted mid-WAIT with complete rising on the next cycle -> all outputs 0, no sample accumulated, and IDLE holds while enable is low.
